seq_signed_mult: RTL and testbench

//  Sequential signed (two's-complement) shift-add multiplier for the P02 datapath.
//  - Operand path: converts each operand to magnitude.
//  - Core: multiplies the magnitudes in DW iterations.
//  - Result path: re-applies the sign by two's complement of the 2*DW product.

---
 rtl/mult_pkg.sv | 6 +
 rtl/a2_complement.sv | 9 +
 rtl/seq_signed_mult.sv | 93 +++++++++
 tb/tb_seq_signed_mult.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential signed multiplier.
package mult_pkg;
  localparam int DW_DEF = 8;
  localparam int CNT_W  = $clog2(DW_DEF);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;
endpackage

// File: rtl/a2_complement.sv
// Two's-complement negator: y = -a, modulo 2^N.
module a2_complement #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);
  assign y = ~a + N'(1);
endmodule

// File: rtl/seq_signed_mult.sv
// Sign-magnitude shift-add multiplier: magnitudes multiplied over DW cycles,
// sign re-applied to the full 2*DW product before the done pulse.
module seq_signed_mult
  import mult_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   multiplier,
  input  logic [DW-1:0]   multiplicand,
  output logic            ready,
  output logic            done,
  output logic            sign,
  output logic [2*DW-1:0] product
);
  localparam int DW_2 = 2*DW;
  localparam int CW   = $clog2(DW);

  state_e          state;
  logic            sign_r;
  logic [DW-1:0]   acc, mplr_mag, mcand_mag;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   mplr_neg, mcand_neg;
  logic [DW_2-1:0] prod_raw, prod_neg;
  logic [DW:0]     sum;
  logic            sign_eff;

  a2_complement #(.N(DW))   u_neg_mplr  (.a(multiplier),   .y(mplr_neg));
  a2_complement #(.N(DW))   u_neg_mcand (.a(multiplicand), .y(mcand_neg));
  a2_complement #(.N(DW_2)) u_neg_prod  (.a(prod_raw),     .y(prod_neg));

  // Upper half accumulates; the multiplier magnitude is consumed from the lower half.
  assign prod_raw = {acc, mplr_mag};
  assign sign_eff = sign_r & (prod_raw != '0);

  always_comb begin
    sum = {1'b0, acc} + (mplr_mag[0] ? {1'b0, mcand_mag} : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      sign      <= 1'b0;
      product   <= '0;
      sign_r    <= 1'b0;
      acc       <= '0;
      mplr_mag  <= '0;
      mcand_mag <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sign_r    <= multiplier[DW-1] ^ multiplicand[DW-1];
            mplr_mag  <= multiplier[DW-1]   ? mplr_neg  : multiplier;
            mcand_mag <= multiplicand[DW-1] ? mcand_neg : multiplicand;
            acc       <= '0;
            cnt       <= CW'(DW-1);
            ready     <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          acc      <= sum[DW:1];
          mplr_mag <= {sum[0], mplr_mag[DW-1:1]};
          cnt      <= cnt - CW'(1);
          if (cnt == '0) state <= SIGN;
        end
        SIGN: begin
          product <= sign_eff ? prod_neg : prod_raw;
          sign    <= sign_eff;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_mult.sv
// Directed and random checks of seq_signed_mult (DW=8) with immediate assertions.
module tb_seq_signed_mult;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  multiplier, multiplicand;
  logic        ready, done, sign;
  logic [15:0] product;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int lat;
  logic prev_done = 1'b0;

  seq_signed_mult #(.DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplier(multiplier),
    .multiplicand(multiplicand), .ready(ready), .done(done), .sign(sign),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Track accept edges so every done pulse can be checked for latency and shape.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ready && start && !rst) acc_cyc <= cyc;
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      lat = cyc - acc_cyc - 1;
      check("done_pulse_prev_low", {31'd0, prev_done}, 32'd0);
      check("ready_done_exclusive", {31'd0, ready}, 32'd0);
      check("latency", lat, 32'd9);
    end
    prev_done <= done;
  end

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] ep, input logic es);
    int n;
    bit seen;
    multiplier = a; multiplicand = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; multiplier = 8'hxx; multiplicand = 8'hxx;
    n = 1;
    seen = done;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = done;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_product"}, {16'd0, product}, {16'd0, ep});
    check({tag, "_sign"}, {31'd0, sign}, {31'd0, es});
    @(negedge clk);
    check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int dcnt;
    logic signed [7:0]  ra, rb;
    logic signed [15:0] re;
    rst = 1'b1; start = 1'b0; multiplier = 8'd0; multiplicand = 8'd0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_sign", {31'd0, sign}, 32'd0);
    @(negedge clk);

    do_op("t1_3x5", 8'd3, 8'd5, 16'h000F, 1'b0);
    do_op("t2_m3x5", 8'hFD, 8'd5, 16'hFFF1, 1'b1);
    do_op("t2_5xm3", 8'd5, 8'hFD, 16'hFFF1, 1'b1);
    do_op("t3_m128xm128", 8'h80, 8'h80, 16'h4000, 1'b0);
    do_op("t3_m128x127", 8'h80, 8'h7F, 16'hC080, 1'b1);
    do_op("t4_0xm7", 8'h00, 8'hF9, 16'h0000, 1'b0);
    do_op("t4_m1xm1", 8'hFF, 8'hFF, 16'h0001, 1'b0);

    // Starts while busy must be dropped.
    multiplier = 8'd3; multiplicand = 8'd5; start = 1'b1;
    dcnt = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 2 || i == 5) begin
        start = 1'b1; multiplier = 8'd7; multiplicand = 8'd7;
      end else start = 1'b0;
      if (done) begin
        dcnt++;
        check("t5_busy_product", {16'd0, product}, 32'h0000000F);
      end
    end
    check("t5_done_count", dcnt, 32'd1);
    do_op("t5_7x7", 8'd7, 8'd7, 16'd49, 1'b0);

    // Reset mid-calculation discards the operation.
    multiplier = 8'd9; multiplicand = 8'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_ready", {31'd0, ready}, 32'd1);
    check("t6_product", {16'd0, product}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("t6_no_done", dcnt, 32'd0);
    do_op("t6_2xm2", 8'd2, 8'hFE, 16'hFFFC, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      re = ra * rb;
      do_op("rand", ra, rb, re, re < 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
